rf_seq_ctrl: RTL and testbench



---
 rtl/rf_seq_pkg.sv | 53 +++++
 rtl/rf_seq_decode.sv | 49 ++++
 rtl/rf_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_rf_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, ALU function
// encodings, FSM states and instruction field positions.
package rf_seq_pkg;

   // Instruction field bit positions
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int DR_HI  = 11;
   localparam int DR_LO  = 9;
   localparam int SA_HI  = 8;
   localparam int SA_LO  = 6;
   localparam int SB_HI  = 5;
   localparam int SB_LO  = 3;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;
   localparam int JT_HI  = 7;
   localparam int JT_LO  = 0;

   // Opcodes (A-E decode as NOP)
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_MOV  = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_BRZ  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   // ALU function select encodings
   localparam logic [2:0] FS_ADD    = 3'd0;
   localparam logic [2:0] FS_SUB    = 3'd1;
   localparam logic [2:0] FS_AND    = 3'd2;
   localparam logic [2:0] FS_OR     = 3'd3;
   localparam logic [2:0] FS_XOR    = 3'd4;
   localparam logic [2:0] FS_PASS_A = 3'd5;
   localparam logic [2:0] FS_PASS_B = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // Ops 1-7 produce a register-file write
   function automatic logic op_writes_rf(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_LDI);
   endfunction

endpackage

// File: rtl/rf_seq_decode.sv
// Combinational instruction decoder: IR -> register selects, ALU controls,
// immediate and instruction class flags.
module rf_seq_decode
   import rf_seq_pkg::*;
(
   input  logic [15:0] ir,
   output logic [2:0]  aa,
   output logic [2:0]  ba,
   output logic [2:0]  da,
   output logic [2:0]  fs,
   output logic        mb,
   output logic [7:0]  imm,
   output logic        writes_rf,
   output logic        is_branch,
   output logic        is_jmp,
   output logic        is_halt
);

   logic [3:0] op;
   assign op = ir[OP_HI:OP_LO];

   // Field extraction and per-opcode ALU control
   always_comb begin
      aa        = ir[SA_HI:SA_LO];
      ba        = ir[SB_HI:SB_LO];
      da        = ir[DR_HI:DR_LO];
      imm       = {2'b00, ir[IMM_HI:IMM_LO]};
      fs        = FS_ADD;
      mb        = 1'b0;
      writes_rf = op_writes_rf(op);
      is_branch = (op == OP_BRZ);
      is_jmp    = (op == OP_JMP);
      is_halt   = (op == OP_HALT);
      case (op)
         OP_ADD:  fs = FS_ADD;
         OP_SUB:  fs = FS_SUB;
         OP_AND:  fs = FS_AND;
         OP_OR:   fs = FS_OR;
         OP_XOR:  fs = FS_XOR;
         OP_MOV:  fs = FS_PASS_A;
         OP_LDI: begin
            fs = FS_PASS_B;
            mb = 1'b1;
         end
         default: fs = FS_ADD;
      endcase
   end

endmodule

// File: rtl/rf_seq_ctrl.sv
// Multi-cycle instruction sequencer driving the 8x8 register file.
// IDLE -> FETCH (req/valid handshake) -> EXEC (one cycle) -> FETCH ... HALT.
// Optional feature macro: RF_SEQ_RETIRE_CNT_EN adds a 16-bit retired-
// instruction counter output.
module rf_seq_ctrl
   import rf_seq_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [15:0]     instr,
   input  logic            Z,
   output logic [2:0]      AA,
   output logic [2:0]      BA,
   output logic [2:0]      DA,
   output logic            RW,
   output logic [2:0]      FS,
   output logic            MB,
   output logic [7:0]      imm,
`ifdef RF_SEQ_RETIRE_CNT_EN
   output logic [15:0]     retired,
`endif
   output logic            halted
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic            req_q, req_d;
   logic            rw_q, rw_d;
   logic            halted_q, halted_d;

   logic            writes_rf, is_branch, is_jmp, is_halt;
   logic signed [5:0] br_off6;
   logic [PC_W-1:0] br_off, jmp_tgt;

   rf_seq_decode u_decode (
      .ir        (ir_q),
      .aa        (AA),
      .ba        (BA),
      .da        (DA),
      .fs        (FS),
      .mb        (MB),
      .imm       (imm),
      .writes_rf (writes_rf),
      .is_branch (is_branch),
      .is_jmp    (is_jmp),
      .is_halt   (is_halt)
   );

   // Branch offset is relative to the already-incremented PC
   assign br_off6 = ir_q[IMM_HI:IMM_LO];
   assign br_off  = PC_W'(br_off6);
   assign jmp_tgt = PC_W'(ir_q[JT_HI:JT_LO]);

   // Next-state logic; RW is precomputed from the incoming word so it is a
   // clean flop output during EXEC
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      req_d    = req_q;
      rw_d     = 1'b0;
      halted_d = halted_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               req_d   = 1'b1;
            end
         end
         ST_FETCH: begin
            if (imem_valid) begin
               ir_d    = instr;
               pc_d    = pc_q + PC_W'(1);
               state_d = ST_EXEC;
               req_d   = 1'b0;
               rw_d    = op_writes_rf(instr[OP_HI:OP_LO]);
            end
         end
         ST_EXEC: begin
            if (is_branch && Z)
               pc_d = pc_q + br_off;
            else if (is_jmp)
               pc_d = jmp_tgt;
            if (is_halt) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = ST_FETCH;
               req_d   = 1'b1;
            end
         end
         ST_HALT: begin
            req_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // FSM, PC, IR and registered control outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         req_q    <= 1'b0;
         rw_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         req_q    <= req_d;
         rw_q     <= rw_d;
         halted_q <= halted_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign RW        = rw_q & writes_rf;
   assign halted    = halted_q;

`ifdef RF_SEQ_RETIRE_CNT_EN
   logic [15:0] ret_q, ret_d;

   // Count every EXEC cycle, wrapping naturally at 16 bits
   always_comb begin
      ret_d = ret_q;
      if (state_q == ST_EXEC)
         ret_d = ret_q + 16'd1;
   end

   // Retired-instruction counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ret_q <= '0;
      else
         ret_q <= ret_d;
   end

   assign retired = ret_q;
`endif

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Self-checking bench for rf_seq_ctrl: directed cases followed by random
// instruction streams with random fetch latency, Z and spurious inputs,
// checked against a PC/decode reference model.
module tb_rf_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_valid;
   logic [15:0] instr;
   logic        Z;
   logic [2:0]  AA, BA, DA, FS;
   logic        RW, MB, halted;
   logic [7:0]  imm;
`ifdef RF_SEQ_RETIRE_CNT_EN
   logic [15:0] retired;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  mpc;
   int          mret;

   rf_seq_ctrl #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .instr      (instr),
      .Z          (Z),
      .AA         (AA),
      .BA         (BA),
      .DA         (DA),
      .RW         (RW),
      .FS         (FS),
      .MB         (MB),
      .imm        (imm),
`ifdef RF_SEQ_RETIRE_CNT_EN
      .retired    (retired),
`endif
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] ref_fs(input logic [3:0] op);
      case (op)
         4'h1: return 3'd0;
         4'h2: return 3'd1;
         4'h3: return 3'd2;
         4'h4: return 3'd3;
         4'h5: return 3'd4;
         4'h6: return 3'd5;
         4'h7: return 3'd6;
         default: return 3'd0;
      endcase
   endfunction

   task automatic do_reset;
      reset = 1'b1; start = 1'b0; imem_valid = 1'b0; instr = '0; Z = 1'b0;
      repeat (2) tick;
      reset = 1'b0;
      mpc  = 8'h00;
      mret = 0;
   endtask

   task automatic do_start;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   // Fetch word w after lat stall cycles, execute it with ALU flag z
   task automatic run_instr(input logic [15:0] w, input int lat, input logic z);
      logic [3:0] op;
      logic [5:0] i6;
      op = w[15:12];
      i6 = w[5:0];
      for (int c = 0; c < lat; c++) begin
         imem_valid = 1'b0;
         instr = 16'($urandom);
         start = 1'($urandom);
         chk("fetch_req", imem_req, 1);
         chk("fetch_addr", imem_addr, mpc);
         chk("fetch_rw", RW, 0);
         tick;
      end
      imem_valid = 1'b1;
      instr = w;
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, mpc);
      tick;
      // EXEC cycle: spurious valid/start must be ignored
      imem_valid = 1'($urandom);
      instr = 16'($urandom);
      start = 1'($urandom);
      Z = z;
      mpc = mpc + 8'd1;
      chk("exec_rw", RW, (op >= 4'h1 && op <= 4'h7));
      chk("exec_req", imem_req, 0);
      chk("exec_halted", halted, 0);
      if (op >= 4'h1 && op <= 4'h7) begin
         chk("exec_da", DA, w[11:9]);
         chk("exec_fs", FS, ref_fs(op));
         chk("exec_mb", MB, (op == 4'h7));
      end
      if ((op >= 4'h1 && op <= 4'h6) || op == 4'h8)
         chk("exec_aa", AA, w[8:6]);
      if (op >= 4'h1 && op <= 4'h5)
         chk("exec_ba", BA, w[5:3]);
      if (op == 4'h7)
         chk("exec_imm", imm, {2'b00, i6});
      if (op == 4'h8 && z)
         mpc = mpc + {{2{i6[5]}}, i6};
      else if (op == 4'h9)
         mpc = w[7:0];
      tick;
      mret++;
      imem_valid = 1'b0;
      start = 1'b0;
`ifdef RF_SEQ_RETIRE_CNT_EN
      chk("retired", retired, mret);
`endif
   endtask

   initial begin
      logic [15:0] w;
      do_reset;
      // Reset state
      chk("rst_req", imem_req, 0);
      chk("rst_rw", RW, 0);
      chk("rst_halted", halted, 0);
      chk("rst_addr", imem_addr, 8'h00);
      chk("rst_ctl", {AA, BA, DA, FS, MB, imm}, 0);
`ifdef RF_SEQ_RETIRE_CNT_EN
      chk("rst_retired", retired, 0);
`endif
      tick;
      chk("idle_req", imem_req, 0);

      // LDI, ADD
      do_start;
      run_instr(16'h7205, 0, 1'b0);
      chk("pc_after_ldi", imem_addr, 8'h01);
      run_instr(16'h1650, 0, 1'b0);

      // BRZ at 0x10, taken and not taken
      run_instr(16'h9010, 0, 1'b0);
      run_instr(16'h803E, 0, 1'b1);
      chk("brz_taken", imem_addr, 8'h0F);
      run_instr(16'h9010, 1, 1'b0);
      run_instr(16'h803E, 0, 1'b0);
      chk("brz_not_taken", imem_addr, 8'h11);

      // Delayed valid, JMP to 0xFF and PC wrap
      run_instr(16'h1650, 3, 1'b0);
      run_instr(16'h90FF, 2, 1'b1);
      chk("jmp_ff", imem_addr, 8'hFF);
      run_instr(16'h0000, 0, 1'b0);
      chk("pc_wrap", imem_addr, 8'h00);

      // Random stream (HALT excluded)
      for (int n = 0; n < 300; n++) begin
         w = 16'($urandom);
         w[15:12] = 4'($urandom_range(0, 14));
         run_instr(w, int'($urandom_range(0, 3)), 1'($urandom));
      end

      // HALT: stays halted, ignores start and valid
      run_instr(16'hF000, 1, 1'b0);
      chk("halt_flag", halted, 1);
      for (int c = 0; c < 20; c++) begin
         start = 1'($urandom);
         imem_valid = 1'($urandom);
         tick;
         chk("halt_req", imem_req, 0);
         chk("halt_stay", halted, 1);
         chk("halt_rw", RW, 0);
      end
      start = 1'b0; imem_valid = 1'b0;
      do_reset;
      chk("halt_rst_flag", halted, 0);
      chk("halt_rst_pc", imem_addr, 8'h00);

      // Async reset mid-EXEC of ADD
      do_start;
      run_instr(16'h7205, 0, 1'b0);
      imem_valid = 1'b1;
      instr = 16'h1650;
      tick;
      imem_valid = 1'b0;
      chk("mid_exec_rw", RW, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rw", RW, 0);
      chk("async_req", imem_req, 0);
      chk("async_addr", imem_addr, 8'h00);
`ifdef RF_SEQ_RETIRE_CNT_EN
      chk("async_retired", retired, 0);
`endif
      imem_valid = 1'b1;
      tick;
      reset = 1'b0;
      tick;
      imem_valid = 1'b0;
      chk("post_rst_idle", imem_req, 0);
      mpc = 8'h00;
      mret = 0;
      do_start;
      run_instr(16'h2A98, 0, 1'b0);
      chk("post_rst_pc", imem_addr, 8'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
